// File: rtl/dsi_line_packetizer_pkg.sv
// dsi_pkg: shared FSM type, byte counts and DSI ECC/CRC helpers for the line packetizer
package dsi_pkg;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, FOOTER} state_t;

    localparam int HDR_BYTES = 4;
    localparam int FTR_BYTES = 2;

    // Each parity bit is the XOR of a fixed subset of the 24 header bits
    function automatic logic [5:0] dsi_ecc24(input logic [23:0] d);
        return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    function automatic logic [15:0] crc16_upd8(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) c = (c >> 1) ^ ((c[0] ^ b[i]) ? 16'h8408 : 16'h0000);
        return c;
    endfunction

endpackage

// File: rtl/dsi_line_packetizer_if.sv
// dsi_line_packetizer_if: byte-strobed packet stream toward the lane distributor
interface dsi_line_packetizer_if;
    logic [31:0] pkt_data;
    logic [3:0]  pkt_strb;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_last;

    modport master (output pkt_data, pkt_strb, pkt_valid, pkt_last, input pkt_ready);
    modport slave  (input pkt_data, pkt_strb, pkt_valid, pkt_last, output pkt_ready);
endinterface

// File: rtl/dsi_line_packetizer_crc.sv
// dsi_crc16_32: registered CRC-16-CCITT (reflected) folding one 32-bit word per enabled cycle
module dsi_crc16_32
    import dsi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [31:0] data,
    output logic [15:0] crc
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) crc <= 16'hFFFF;
        else if (init) crc <= 16'hFFFF;
        else if (en) crc <= crc16_upd8(crc16_upd8(crc16_upd8(crc16_upd8(crc, data[7:0]),
                                       data[15:8]), data[23:16]), data[31:24]);
endmodule

// File: rtl/dsi_line_packetizer.sv
// dsi_line_packetizer: frames each video line from the pixel FIFO as one DSI long packet
module dsi_line_packetizer
    import dsi_pkg::*;
#(
    parameter int WC_W       = 16,
    parameter bit CRC_ENABLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 pix_fifo_read,
    input  logic [31:0]          pix_fifo_data,
    input  logic                 pix_fifo_empty,
    input  logic                 enable,
    input  logic                 line_request,
    input  logic [WC_W-1:0]      line_size,
    input  logic [5:0]           data_type,
    input  logic [1:0]           virtual_channel,
    dsi_line_packetizer_if.master pkt,
    output logic                 busy,
    output logic                 line_done,
    output logic                 underflow_err
);
    localparam int CW = WC_W - 2;

    state_t          state;
    logic [WC_W-1:0] wc;
    logic [5:0]      dt;
    logic [1:0]      vc;
    logic [CW-1:0]   to_read, to_send;
    logic [31:0]     skid0, skid1;
    logic [1:0]      cnt, keep;
    logic            rd_q, start, pop;
    logic [15:0]     crc;
    logic [23:0]     hdr;

    assign hdr   = {16'(wc), vc, dt};
    assign start = state == IDLE && line_request && enable;
    assign pop   = state == PAYLOAD && cnt != 2'd0 && pkt.pkt_ready;
    assign keep  = cnt - {1'b0, pop};

    // Occupancy after this cycle's pop lets the skid refill at full rate
    assign pix_fifo_read = !pix_fifo_empty && to_read != '0 && (keep + {1'b0, rd_q}) < 2'd2;

    assign pkt.pkt_valid = state == HEADER || state == FOOTER || (state == PAYLOAD && cnt != 2'd0);
    assign pkt.pkt_data  = state == HEADER  ? {2'b00, dsi_ecc24(hdr), hdr} :
                           state == PAYLOAD ? skid0 :
                           state == FOOTER  ? {16'h0000, CRC_ENABLE ? crc : 16'h0000} : 32'h0;
    assign pkt.pkt_strb  = state == IDLE   ? 4'h0 :
                           state == FOOTER ? 4'((1 << FTR_BYTES) - 1) : 4'((1 << HDR_BYTES) - 1);
    assign pkt.pkt_last  = state == FOOTER;
    assign busy          = state != IDLE;
    assign line_done     = state == FOOTER && pkt.pkt_ready;

    dsi_crc16_32 u_crc (.clk(clk), .rst_n(rst_n), .init(start), .en(pop), .data(skid0), .crc(crc));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            wc            <= '0;
            dt            <= '0;
            vc            <= '0;
            to_read       <= '0;
            to_send       <= '0;
            skid0         <= '0;
            skid1         <= '0;
            cnt           <= '0;
            rd_q          <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            rd_q <= pix_fifo_read;
            cnt  <= keep + {1'b0, rd_q};
            if (rd_q && keep == 2'd0) skid0 <= pix_fifo_data;
            else if (pop) skid0 <= skid1;
            if (rd_q && keep == 2'd1) skid1 <= pix_fifo_data;
            if (pix_fifo_read) to_read <= to_read - 1'b1;
            if (pop) to_send <= to_send - 1'b1;
            if (state == PAYLOAD && cnt == 2'd0 && !rd_q && pix_fifo_empty) underflow_err <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state         <= HEADER;
                    wc            <= line_size & ~WC_W'(3);
                    dt            <= data_type;
                    vc            <= virtual_channel;
                    to_read       <= line_size[WC_W-1:2];
                    to_send       <= line_size[WC_W-1:2];
                    underflow_err <= 1'b0;
                end
                HEADER:  if (pkt.pkt_ready) state <= wc == '0 ? FOOTER : PAYLOAD;
                PAYLOAD: if (pop && to_send == CW'(1)) state <= FOOTER;
                default: if (pkt.pkt_ready) state <= IDLE;
            endcase
        end
endmodule
